// File: rtl/ultrasonic_scanner.sv
// Multi-channel ultrasonic ranger scanner: round-robins trigger/echo measurement
// over the enabled channels and keeps one result and timeout flag per channel.
module ultrasonic_scanner #(
   parameter int N_CH        = 4,
   parameter int VAL_W       = 16,
   parameter int TRIG_CYCLES = 1200,
   parameter int SLOT_CYCLES = 25_000_000,
   parameter int TICK_CYCLES = 50,
   localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [N_CH-1:0]  ch_mask,
   input  logic [N_CH-1:0]  echo,
   output logic [N_CH-1:0]  trig,
   input  logic [SEL_W-1:0] rd_sel,
   output logic [VAL_W-1:0] rd_value,
   output logic             rd_timeout,
   output logic             done_stb,
   output logic [SEL_W-1:0] done_ch,
   output logic             busy
);

   localparam int SLOT_W = $clog2(SLOT_CYCLES);
   localparam int TRIG_W = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
   localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
   localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
   localparam logic [VAL_W-1:0]  VAL_SAT   = {{(VAL_W-1){1'b1}}, 1'b0};

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_WAIT_RISE,
      S_MEASURE,
      S_HOLDOFF
   } state_t;

   state_t             r_state;
   logic [SEL_W-1:0]   r_cur;
   logic [SLOT_W-1:0]  r_slotCnt;
   logic [TRIG_W-1:0]  r_trigCnt;
   logic [TICK_W-1:0]  r_tickCnt;
   logic [VAL_W-1:0]   r_resCnt;
   logic [N_CH-1:0]    r_trig;
   logic               r_doneStb;
   logic [SEL_W-1:0]   r_doneCh;
   logic [N_CH-1:0]    r_echoMeta;
   logic [N_CH-1:0]    r_echoSync;
   logic [N_CH-1:0]    r_echoDly;
   logic [VAL_W-1:0]   r_value [N_CH];
   logic [N_CH-1:0]    r_timeout;

   logic               w_echoNow;
   logic               w_echoPrev;
   logic               w_rise;
   logic               w_fall;
   logic               w_slotEnd;
   logic               w_anyCh;
   logic [SEL_W-1:0]   w_firstCh;
   logic [SEL_W-1:0]   w_nextCh;
   logic               w_slotAdvance;
   logic               w_wrEn;
   logic [VAL_W-1:0]   w_wrVal;
   logic               w_wrTo;

   // First set bit of mask strictly above cur, wrapping around through index 0.
   function automatic logic [SEL_W-1:0] nextSetCh(input logic [N_CH-1:0] mask,
                                                  input logic [SEL_W-1:0] cur);
      logic [SEL_W-1:0] res;
      logic             found;
      int               idx;
      res   = '0;
      found = 1'b0;
      for (int i = 1; i <= N_CH; i++) begin
         idx = int'(cur) + i;
         if (idx >= N_CH) idx = idx - N_CH;
         if (!found && mask[idx[SEL_W-1:0]]) begin
            res   = idx[SEL_W-1:0];
            found = 1'b1;
         end
      end
      return res;
   endfunction

   function automatic logic [N_CH-1:0] oneHot(input logic [SEL_W-1:0] idx);
      logic [N_CH-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   assign w_echoNow     = r_echoSync[r_cur];
   assign w_echoPrev    = r_echoDly[r_cur];
   assign w_rise        = w_echoNow & ~w_echoPrev;
   assign w_fall        = ~w_echoNow & w_echoPrev;
   assign w_slotEnd     = (r_slotCnt == SLOT_LAST);
   assign w_anyCh       = |ch_mask;
   assign w_firstCh     = nextSetCh(ch_mask, SEL_W'(N_CH - 1));
   assign w_nextCh      = nextSetCh(ch_mask, r_cur);
   assign w_slotAdvance = enable && w_slotEnd &&
                          (r_state == S_WAIT_RISE || r_state == S_MEASURE || r_state == S_HOLDOFF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_echoMeta <= '0;
         r_echoSync <= '0;
         r_echoDly  <= '0;
      end else begin
         r_echoMeta <= echo;
         r_echoSync <= r_echoMeta;
         r_echoDly  <= r_echoSync;
      end
   end

   // A falling edge coinciding with slot end keeps the measured value; otherwise
   // reaching slot end while still waiting or measuring is a timeout.
   always_comb begin
      w_wrEn  = 1'b0;
      w_wrVal = r_resCnt;
      w_wrTo  = 1'b0;
      if (enable) begin
         case (r_state)
            S_WAIT_RISE: begin
               if (w_slotEnd) begin
                  w_wrEn  = 1'b1;
                  w_wrVal = '1;
                  w_wrTo  = 1'b1;
               end
            end
            S_MEASURE: begin
               if (w_fall) begin
                  w_wrEn = 1'b1;
               end else if (w_slotEnd) begin
                  w_wrEn  = 1'b1;
                  w_wrVal = '1;
                  w_wrTo  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Slot end always hands over to the next channel in the same cycle, so
   // consecutive triggers stay exactly one slot apart whatever state we were in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cur     <= '0;
         r_slotCnt <= '0;
         r_trigCnt <= '0;
         r_tickCnt <= '0;
         r_resCnt  <= '0;
         r_trig    <= '0;
         r_doneStb <= 1'b0;
         r_doneCh  <= '0;
      end else begin
         r_doneStb <= w_wrEn;
         if (w_wrEn) r_doneCh <= r_cur;
         if (r_state != S_IDLE) r_slotCnt <= r_slotCnt + 1'b1;

         if (!enable) begin
            r_state <= S_IDLE;
            r_trig  <= '0;
         end else if (w_slotAdvance) begin
            if (w_anyCh) begin
               r_cur     <= w_nextCh;
               r_state   <= S_TRIG;
               r_trig    <= oneHot(w_nextCh);
               r_slotCnt <= '0;
               r_trigCnt <= '0;
            end else begin
               r_state <= S_IDLE;
            end
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_anyCh) begin
                     r_cur     <= w_firstCh;
                     r_state   <= S_TRIG;
                     r_trig    <= oneHot(w_firstCh);
                     r_slotCnt <= '0;
                     r_trigCnt <= '0;
                  end
               end
               S_TRIG: begin
                  r_trigCnt <= r_trigCnt + 1'b1;
                  if (r_trigCnt == TRIG_LAST) begin
                     r_trig  <= '0;
                     r_state <= S_WAIT_RISE;
                  end
               end
               S_WAIT_RISE: begin
                  if (w_rise) begin
                     r_tickCnt <= '0;
                     r_resCnt  <= '0;
                     r_state   <= S_MEASURE;
                  end
               end
               S_MEASURE: begin
                  if (w_fall) begin
                     r_state <= S_HOLDOFF;
                  end else if (r_tickCnt == TICK_LAST) begin
                     r_tickCnt <= '0;
                     if (r_resCnt != VAL_SAT) r_resCnt <= r_resCnt + 1'b1;
                  end else begin
                     r_tickCnt <= r_tickCnt + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) r_value[i] <= '0;
         r_timeout <= '0;
      end else if (w_wrEn) begin
         r_value[r_cur]   <= w_wrVal;
         r_timeout[r_cur] <= w_wrTo;
      end
   end

   // Selects beyond the last channel read as zero when N_CH is not a power of two.
   generate
      if (N_CH == (1 << SEL_W)) begin : g_fullSel
         assign rd_value   = r_value[rd_sel];
         assign rd_timeout = r_timeout[rd_sel];
      end else begin : g_partSel
         assign rd_value   = (int'(rd_sel) < N_CH) ? r_value[rd_sel] : '0;
         assign rd_timeout = (int'(rd_sel) < N_CH) ? r_timeout[rd_sel] : 1'b0;
      end
   endgenerate

   assign trig     = r_trig;
   assign done_stb = r_doneStb;
   assign done_ch  = r_doneCh;
   assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_ultrasonic_scanner.sv
// Directed bench for ultrasonic_scanner; a second instance with a long slot
// covers result saturation.
module tb_ultrasonic_scanner;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       enable  = 1'b0;
   logic [3:0] ch_mask = '0;
   logic [3:0] echo    = '0;
   logic [1:0] rd_sel  = '0;

   logic [3:0] trig, trigL;
   logic [7:0] rdValue, rdValueL;
   logic       rdTimeout, rdTimeoutL;
   logic       doneStb, doneStbL;
   logic [1:0] doneCh, doneChL;
   logic       busy, busyL;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   ultrasonic_scanner #(
      .N_CH(4), .VAL_W(8), .TRIG_CYCLES(4), .SLOT_CYCLES(200), .TICK_CYCLES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask), .echo(echo),
      .trig(trig), .rd_sel(rd_sel), .rd_value(rdValue), .rd_timeout(rdTimeout),
      .done_stb(doneStb), .done_ch(doneCh), .busy(busy)
   );

   ultrasonic_scanner #(
      .N_CH(4), .VAL_W(8), .TRIG_CYCLES(4), .SLOT_CYCLES(1000), .TICK_CYCLES(2)
   ) dutLong (
      .clk(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask), .echo(echo),
      .trig(trigL), .rd_sel(rd_sel), .rd_value(rdValueL), .rd_timeout(rdTimeoutL),
      .done_stb(doneStbL), .done_ch(doneChL), .busy(busyL)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic doReset();
      enable  = 1'b0;
      ch_mask = '0;
      echo    = '0;
      rd_sel  = '0;
      @(negedge clk);
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic waitTrig(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (trig != 4'b0000) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic waitTrigLow(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (trig == 4'b0000) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic waitDone(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (doneStb === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic waitDoneLong(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (doneStbL === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic echoPulse(input int ch, input int width);
      echo[ch] = 1'b1;
      tick(width);
      echo[ch] = 1'b0;
   endtask

   task automatic test_reset();
      enable  = 1'b1;
      ch_mask = 4'b1111;
      echo    = '0;
      rst_n   = 1'b0;
      tick(4);
      checks++;
      if (trig !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_trig got %b want 0000", trig);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_busy got %b want 0", busy);
      end
      checks++;
      if (doneStb !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_done_stb got %b want 0", doneStb);
      end
      for (int s = 0; s < 4; s++) begin
         rd_sel = 2'(s);
         #1;
         checks++;
         if (rdValue !== 8'h00 || rdTimeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_rd_ch%0d got value %h timeout %b want 00/0", s, rdValue, rdTimeout);
         end
      end
      enable = 1'b0;
      rst_n  = 1'b1;
      tick(1);
   endtask

   task automatic test_single_channel();
      bit ok;
      int t0, hi;
      doReset();
      ch_mask = 4'b0001;
      enable  = 1'b1;
      waitTrig(10, ok);
      t0 = cycle;
      checks++;
      if (!ok || trig !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL single_trig_onehot got %b want 0001", trig);
      end
      hi = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (trig[0]) hi++;
         else break;
      end
      checks++;
      if (hi != 4) begin
         errors++;
         $display("[TB] FAIL single_trig_width got %0d want 4", hi);
      end
      tick(10);
      echoPulse(0, 40);
      waitDone(20, ok);
      checks++;
      if (!ok || doneCh !== 2'd0) begin
         errors++;
         $display("[TB] FAIL single_done got stb_seen %b ch %0d want 1/0", ok, doneCh);
      end
      tick(1);
      rd_sel = 2'd0;
      #1;
      checks++;
      if ($isunknown(rdValue) || rdValue < 8'd19 || rdValue > 8'd21 || rdTimeout !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_value got %0d timeout %b want 19..21/0", rdValue, rdTimeout);
      end
      waitTrig(250, ok);
      checks++;
      if (!ok || (cycle - t0) != 200) begin
         errors++;
         $display("[TB] FAIL single_period got %0d want 200", cycle - t0);
      end
   endtask

   task automatic test_round_robin();
      bit         ok;
      logic [3:0] expTrig [4];
      int         chIdx   [3];
      int         widths  [3];
      int         mids    [3];
      expTrig = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
      chIdx   = '{0, 1, 3};
      widths  = '{20, 60, 100};
      mids    = '{10, 30, 50};
      doReset();
      ch_mask = 4'b1011;
      enable  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         waitTrig(250, ok);
         checks++;
         if (!ok || trig !== expTrig[k]) begin
            errors++;
            $display("[TB] FAIL rr_order_%0d got %b want %b", k, trig, expTrig[k]);
         end
         waitTrigLow(10, ok);
         if (k < 3) begin
            tick(10);
            echoPulse(chIdx[k], widths[k]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         rd_sel = 2'(chIdx[i]);
         #1;
         checks++;
         if ($isunknown(rdValue) || int'(rdValue) < mids[i] - 1 || int'(rdValue) > mids[i] + 1 ||
             rdTimeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rr_value_ch%0d got %0d timeout %b want %0d+-1/0",
                     chIdx[i], rdValue, rdTimeout, mids[i]);
         end
      end
      rd_sel = 2'd2;
      #1;
      checks++;
      if (rdValue !== 8'h00 || rdTimeout !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rr_masked_ch2 got %h/%b want 00/0", rdValue, rdTimeout);
      end
   endtask

   task automatic test_timeouts();
      bit ok;
      doReset();
      ch_mask = 4'b0010;
      enable  = 1'b1;
      waitTrig(10, ok);
      checks++;
      if (!ok || trig !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL to_trig got %b want 0010", trig);
      end
      waitDone(210, ok);
      checks++;
      if (!ok || doneCh !== 2'd1) begin
         errors++;
         $display("[TB] FAIL to_noecho_done got stb_seen %b ch %0d want 1/1", ok, doneCh);
      end
      tick(1);
      rd_sel = 2'd1;
      #1;
      checks++;
      if (rdValue !== 8'hFF || rdTimeout !== 1'b1) begin
         errors++;
         $display("[TB] FAIL to_noecho_result got %h/%b want ff/1", rdValue, rdTimeout);
      end

      doReset();
      echo[1] = 1'b1;
      tick(5);
      ch_mask = 4'b0010;
      enable  = 1'b1;
      waitDone(220, ok);
      checks++;
      if (!ok || doneCh !== 2'd1) begin
         errors++;
         $display("[TB] FAIL to_stuck_done got stb_seen %b ch %0d want 1/1", ok, doneCh);
      end
      tick(1);
      rd_sel = 2'd1;
      #1;
      checks++;
      if (rdValue !== 8'hFF || rdTimeout !== 1'b1) begin
         errors++;
         $display("[TB] FAIL to_stuck_result got %h/%b want ff/1", rdValue, rdTimeout);
      end
      echo = '0;
   endtask

   task automatic test_saturation();
      bit ok;
      doReset();
      ch_mask = 4'b0001;
      enable  = 1'b1;
      waitTrig(10, ok);
      waitTrigLow(10, ok);
      tick(10);
      echoPulse(0, 600);
      waitDoneLong(20, ok);
      checks++;
      if (!ok || doneChL !== 2'd0) begin
         errors++;
         $display("[TB] FAIL sat_done got stb_seen %b ch %0d want 1/0", ok, doneChL);
      end
      tick(1);
      rd_sel = 2'd0;
      #1;
      checks++;
      if (rdValueL !== 8'hFE || rdTimeoutL !== 1'b0) begin
         errors++;
         $display("[TB] FAIL sat_value got %h/%b want fe/0", rdValueL, rdTimeoutL);
      end
   endtask

   task automatic test_midslot_disable();
      bit ok;
      int doneCount;
      doReset();
      ch_mask = 4'b0011;
      enable  = 1'b1;
      waitTrig(10, ok);
      waitTrigLow(10, ok);
      tick(10);
      echoPulse(0, 20);
      waitTrig(250, ok);
      checks++;
      if (!ok || trig !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL dis_second_trig got %b want 0010", trig);
      end
      waitTrigLow(10, ok);
      tick(10);
      echo[1] = 1'b1;
      tick(10);
      enable = 1'b0;
      tick(1);
      checks++;
      if (busy !== 1'b0 || trig !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL dis_idle got busy %b trig %b want 0/0000", busy, trig);
      end
      doneCount = (doneStb === 1'b1) ? 1 : 0;
      for (int i = 0; i < 30; i++) begin
         if (i == 5) echo[1] = 1'b0;
         @(negedge clk);
         if (doneStb === 1'b1) doneCount++;
      end
      checks++;
      if (doneCount != 0) begin
         errors++;
         $display("[TB] FAIL dis_no_done got %0d pulses want 0", doneCount);
      end
      rd_sel = 2'd0;
      #1;
      checks++;
      if ($isunknown(rdValue) || rdValue < 8'd9 || rdValue > 8'd11 || rdTimeout !== 1'b0) begin
         errors++;
         $display("[TB] FAIL dis_keep_ch0 got %0d/%b want 9..11/0", rdValue, rdTimeout);
      end
      rd_sel = 2'd1;
      #1;
      checks++;
      if (rdValue !== 8'h00 || rdTimeout !== 1'b0) begin
         errors++;
         $display("[TB] FAIL dis_ch1_unwritten got %h/%b want 00/0", rdValue, rdTimeout);
      end
      tick(1);
      enable = 1'b1;
      waitTrig(10, ok);
      checks++;
      if (!ok || trig !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL dis_restart got %b want 0001", trig);
      end
   endtask

   task automatic test_mask_change();
      bit ok;
      bit fell;
      int t0, fallCycle, trigSeen;
      doReset();
      ch_mask = 4'b0110;
      enable  = 1'b1;
      waitTrig(10, ok);
      t0 = cycle;
      checks++;
      if (!ok || trig !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL mask_first_trig got %b want 0010", trig);
      end
      waitTrigLow(10, ok);
      tick(10);
      echoPulse(1, 20);
      waitDone(20, ok);
      checks++;
      if (!ok || doneCh !== 2'd1) begin
         errors++;
         $display("[TB] FAIL mask_done got stb_seen %b ch %0d want 1/1", ok, doneCh);
      end
      ch_mask = 4'b0000;
      tick(1);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mask_holdoff_busy got %b want 1", busy);
      end
      fell      = 1'b0;
      fallCycle = 0;
      trigSeen  = 0;
      for (int i = 0; i < 250; i++) begin
         @(negedge clk);
         if (trig != 4'b0000) trigSeen++;
         if (busy === 1'b0) begin
            fell      = 1'b1;
            fallCycle = cycle;
            break;
         end
      end
      checks++;
      if (!fell || (fallCycle - t0) != 200) begin
         errors++;
         $display("[TB] FAIL mask_idle_at_slot_end got fell %b at %0d want 1 at 200", fell, fallCycle - t0);
      end
      checks++;
      if (trigSeen != 0) begin
         errors++;
         $display("[TB] FAIL mask_no_retrigger got %0d trig cycles want 0", trigSeen);
      end
   endtask

   initial begin
      test_reset();
      test_single_channel();
      test_round_robin();
      test_timeouts();
      test_saturation();
      test_midslot_disable();
      test_mask_change();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
